// File: rtl/riscv_pkg.sv
// Shared RV32I core types and constants used by the pipeline stages.
package riscv_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  // Writeback source select; code 11 is reserved and behaves as ALU.
  typedef enum logic [1:0] {
    RES_ALU  = 2'b00,
    RES_LOAD = 2'b01,
    RES_PC4  = 2'b10,
    RES_RSVD = 2'b11
  } result_src_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [REG_AW-1:0] X0 = 5'd0;

  // Control fields carried through the MEM/WB register.
  typedef struct packed {
    logic              valid;
    logic              reg_write;
    result_src_e       result_src;
    logic [2:0]        funct3;
    logic [REG_AW-1:0] rd;
  } w_ctrl_t;

endpackage

// File: rtl/mem_wb_stage_load_extend.sv
// Load byte/halfword/word extraction with sign/zero extension and alignment check.
module load_extend
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = riscv_pkg::XLEN
) (
  input  logic [XLEN-1:0] word,
  input  logic [1:0]      offset,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data,
  output logic            misaligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Select the addressed lane, then extend according to the load type.
  always_comb begin
    byte_sel   = 8'(word >> {offset, 3'b000});
    half_sel   = 16'(word >> {offset[1], 4'b0000});
    data       = word;
    misaligned = 1'b0;
    case (funct3)
      F3_LB:  data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LBU: data = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LH: begin
        data       = {{(XLEN-16){half_sel[15]}}, half_sel};
        misaligned = offset[0];
      end
      F3_LHU: begin
        data       = {{(XLEN-16){1'b0}}, half_sel};
        misaligned = offset[0];
      end
      default: begin
        // LW and reserved encodings take the full word.
        data       = word;
        misaligned = (offset != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register, writeback mux and retired-instruction counter.
module mem_wb_stage
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN      = riscv_pkg::XLEN,
  parameter int unsigned INSTRET_W = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall_w,
  input  logic                 flush_w,
  input  logic                 valid_m,
  input  logic                 reg_write_m,
  input  logic [1:0]           result_src_m,
  input  logic [2:0]           funct3_m,
  input  logic [4:0]           rd_m,
  input  logic [XLEN-1:0]      alu_result_m,
  input  logic [XLEN-1:0]      read_data_m,
  input  logic [XLEN-1:0]      pc_plus4_m,
  output logic                 reg_write_w,
  output logic [4:0]           rd_w,
  output logic [XLEN-1:0]      result_w,
  output logic                 valid_w,
  output logic                 misaligned_w,
  output logic [INSTRET_W-1:0] instret
);

  w_ctrl_t                ctrl_q, ctrl_d;
  logic [XLEN-1:0]        alu_result_q, alu_result_d;
  logic [XLEN-1:0]        read_data_q, read_data_d;
  logic [XLEN-1:0]        pc_plus4_q, pc_plus4_d;
  logic [INSTRET_W-1:0]   instret_q, instret_d;

  logic [XLEN-1:0]        load_data;
  logic                   load_mis;

  load_extend #(
    .XLEN (XLEN)
  ) u_load_extend (
    .word       (read_data_q),
    .offset     (alu_result_q[1:0]),
    .funct3     (ctrl_q.funct3),
    .data       (load_data),
    .misaligned (load_mis)
  );

  // W-stage outputs decoded purely from the W register contents.
  always_comb begin
    valid_w      = ctrl_q.valid;
    rd_w         = ctrl_q.rd;
    instret      = instret_q;
    misaligned_w = ctrl_q.valid && (ctrl_q.result_src == RES_LOAD) && load_mis;
    reg_write_w  = ctrl_q.valid && ctrl_q.reg_write && (ctrl_q.rd != X0) && !misaligned_w;
    case (ctrl_q.result_src)
      RES_LOAD: result_w = load_data;
      RES_PC4:  result_w = pc_plus4_q;
      default:  result_w = alu_result_q;
    endcase
  end

  // Next W register contents (flush > stall > capture) and retire counting.
  always_comb begin
    ctrl_d       = ctrl_q;
    alu_result_d = alu_result_q;
    read_data_d  = read_data_q;
    pc_plus4_d   = pc_plus4_q;
    instret_d    = instret_q;

    if (flush_w) begin
      ctrl_d       = '0;
      alu_result_d = '0;
      read_data_d  = '0;
      pc_plus4_d   = '0;
    end else if (!stall_w) begin
      ctrl_d.valid      = valid_m;
      ctrl_d.reg_write  = reg_write_m;
      ctrl_d.result_src = result_src_e'(result_src_m);
      ctrl_d.funct3     = funct3_m;
      ctrl_d.rd         = rd_m;
      alu_result_d      = alu_result_m;
      read_data_d       = read_data_m;
      pc_plus4_d        = pc_plus4_m;
    end

    // An instruction retires when it leaves W normally; a flush discards it.
    if (ctrl_q.valid && !stall_w && !flush_w && !misaligned_w) begin
      instret_d = instret_q + INSTRET_W'(1);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q       <= '0;
      alu_result_q <= '0;
      read_data_q  <= '0;
      pc_plus4_q   <= '0;
      instret_q    <= '0;
    end else begin
      ctrl_q       <= ctrl_d;
      alu_result_q <= alu_result_d;
      read_data_q  <= read_data_d;
      pc_plus4_q   <= pc_plus4_d;
      instret_q    <= instret_d;
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed literal checks plus a random run against a model.
module tb_mem_wb_stage;

  logic        clk;
  logic        reset;
  logic        stall_w;
  logic        flush_w;
  logic        valid_m;
  logic        reg_write_m;
  logic [1:0]  result_src_m;
  logic [2:0]  funct3_m;
  logic [4:0]  rd_m;
  logic [31:0] alu_result_m;
  logic [31:0] read_data_m;
  logic [31:0] pc_plus4_m;
  logic        reg_write_w;
  logic [4:0]  rd_w;
  logic [31:0] result_w;
  logic        valid_w;
  logic        misaligned_w;
  logic [63:0] instret;

  int total = 0;
  int bad   = 0;

  mem_wb_stage dut (
    .clk          (clk),
    .reset        (reset),
    .stall_w      (stall_w),
    .flush_w      (flush_w),
    .valid_m      (valid_m),
    .reg_write_m  (reg_write_m),
    .result_src_m (result_src_m),
    .funct3_m     (funct3_m),
    .rd_m         (rd_m),
    .alu_result_m (alu_result_m),
    .read_data_m  (read_data_m),
    .pc_plus4_m   (pc_plus4_m),
    .reg_write_w  (reg_write_w),
    .rd_w         (rd_w),
    .result_w     (result_w),
    .valid_w      (valid_w),
    .misaligned_w (misaligned_w),
    .instret      (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic        md_valid, md_rw;
  logic [1:0]  md_src;
  logic [2:0]  md_f3;
  logic [4:0]  md_rd;
  logic [31:0] md_alu, md_rdata, md_pc4;
  logic [63:0] md_instret;
  bit          armed = 0;

  // Value a load of this kind returns, and whether the address is unaligned for it.
  function automatic logic [31:0] load_value(input logic [31:0] word, input logic [1:0] off,
                                             input logic [2:0] f3, output bit mis);
    logic [31:0] b, h;
    b = (word >> (8 * off)) & 32'hFF;
    h = (word >> (16 * (off / 2))) & 32'hFFFF;
    mis = 0;
    case (f3)
      3'd0: return (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
      3'd4: return b;
      3'd1: begin mis = (off % 2) != 0; return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h; end
      3'd5: begin mis = (off % 2) != 0; return h; end
      default: begin mis = (off != 0); return word; end
    endcase
  endfunction

  function automatic void model_out(output logic rw, output logic [31:0] res, output logic mis);
    bit lm;
    logic [31:0] lv;
    lv  = load_value(md_rdata, md_alu[1:0], md_f3, lm);
    mis = md_valid && (md_src == 2'd1) && lm;
    rw  = md_valid && md_rw && (md_rd != 0) && !mis;
    res = (md_src == 2'd1) ? lv : (md_src == 2'd2) ? md_pc4 : md_alu;
  endfunction

  always @(posedge clk) begin
    logic        e_rw, e_mis;
    logic [31:0] e_res;
    if (reset) begin
      {md_valid, md_rw, md_src, md_f3, md_rd} = '0;
      {md_alu, md_rdata, md_pc4} = '0;
      md_instret = 0;
      armed = 1;
    end else begin
      model_out(e_rw, e_res, e_mis);
      if (md_valid && !stall_w && !flush_w && !e_mis) md_instret = md_instret + 1;
      if (flush_w) begin
        {md_valid, md_rw, md_src, md_f3, md_rd} = '0;
        {md_alu, md_rdata, md_pc4} = '0;
      end else if (!stall_w) begin
        md_valid = valid_m; md_rw = reg_write_m; md_src = result_src_m;
        md_f3 = funct3_m; md_rd = rd_m; md_alu = alu_result_m;
        md_rdata = read_data_m; md_pc4 = pc_plus4_m;
      end
    end
  end

  // The hazard unit never raises stall and flush together.
  always @(posedge clk) begin
    assert (!(stall_w && flush_w)) else $error("stall_w and flush_w both asserted");
  end

  // Cycle-by-cycle comparison of every W output against the model.
  always @(negedge clk) begin
    logic        e_rw, e_mis;
    logic [31:0] e_res;
    if (armed) begin
      model_out(e_rw, e_res, e_mis);
      chk("m_valid_w", 64'(valid_w), 64'(md_valid));
      chk("m_rd_w", 64'(rd_w), 64'(md_rd));
      chk("m_reg_write_w", 64'(reg_write_w), 64'(e_rw));
      chk("m_misaligned_w", 64'(misaligned_w), 64'(e_mis));
      chk("m_result_w", 64'(result_w), 64'(e_res));
      chk("m_instret", instret, md_instret);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rw, input logic [1:0] src, input logic [2:0] f3,
                       input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] rdata,
                       input logic [31:0] pc4);
    valid_m = v; reg_write_m = rw; result_src_m = src; funct3_m = f3;
    rd_m = rd; alu_result_m = alu; read_data_m = rdata; pc_plus4_m = pc4;
  endtask

  task automatic idle();
    drive(0, 0, 2'd0, 3'd0, 5'd0, 32'h0, 32'h0, 32'h0);
  endtask

  localparam logic [31:0] WORD = 32'h8070_F0A5;

  initial begin
    reset = 1; stall_w = 0; flush_w = 0;
    idle();
    tick(); tick();
    reset = 0;
    chk("rst_valid", 64'(valid_w), 64'd0);
    chk("rst_rw", 64'(reg_write_w), 64'd0);
    chk("rst_result", 64'(result_w), 64'd0);
    chk("rst_instret", instret, 64'd0);

    // ALU write
    drive(1, 1, 2'd0, 3'd0, 5'd5, 32'h1234, 32'h0, 32'h0); tick();
    chk("alu_rw", 64'(reg_write_w), 64'd1);
    chk("alu_rd", 64'(rd_w), 64'd5);
    chk("alu_result", 64'(result_w), 64'h1234);
    chk("alu_instret0", instret, 64'd0);
    idle(); tick();
    chk("alu_instret1", instret, 64'd1);

    // Loads from one memory word
    drive(1, 1, 2'd1, 3'b000, 5'd2, 32'h100, WORD, 32'h0); tick();
    chk("lb_off0", 64'(result_w), 64'hFFFF_FFA5);
    drive(1, 1, 2'd1, 3'b100, 5'd2, 32'h101, WORD, 32'h0); tick();
    chk("lbu_off1", 64'(result_w), 64'h0000_00F0);
    drive(1, 1, 2'd1, 3'b001, 5'd2, 32'h102, WORD, 32'h0); tick();
    chk("lh_off2", 64'(result_w), 64'hFFFF_8070);
    drive(1, 1, 2'd1, 3'b101, 5'd2, 32'h102, WORD, 32'h0); tick();
    chk("lhu_off2", 64'(result_w), 64'h0000_8070);
    drive(1, 1, 2'd1, 3'b010, 5'd2, 32'h100, WORD, 32'h0); tick();
    chk("lw_off0", 64'(result_w), 64'h8070_F0A5);
    chk("lw_instret", instret, 64'd5);

    // Misaligned loads
    drive(1, 1, 2'd1, 3'b010, 5'd7, 32'h102, WORD, 32'h0); tick();
    chk("lw_mis", 64'(misaligned_w), 64'd1);
    chk("lw_mis_rw", 64'(reg_write_w), 64'd0);
    chk("lw_mis_instret", instret, 64'd6);
    drive(1, 1, 2'd1, 3'b001, 5'd7, 32'h103, WORD, 32'h0); tick();
    chk("lh_mis", 64'(misaligned_w), 64'd1);
    chk("lh_mis_instret", instret, 64'd6);
    idle(); tick();
    chk("mis_not_counted", instret, 64'd6);

    // Stall holds W for three cycles
    drive(1, 1, 2'd0, 3'd0, 5'd3, 32'h33, 32'h0, 32'h0); tick();
    stall_w = 1;
    drive(1, 1, 2'd0, 3'd0, 5'd9, 32'h99, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_rd", 64'(rd_w), 64'd3);
      chk("stall_result", 64'(result_w), 64'h33);
      chk("stall_instret", instret, 64'd6);
    end
    stall_w = 0; idle(); tick();
    chk("stall_release_instret", instret, 64'd7);

    // Flush discards the W instruction without counting it
    drive(1, 1, 2'd0, 3'd0, 5'd4, 32'h44, 32'h0, 32'h0); tick();
    flush_w = 1; tick();
    flush_w = 0;
    chk("flush_valid", 64'(valid_w), 64'd0);
    chk("flush_rw", 64'(reg_write_w), 64'd0);
    chk("flush_instret", instret, 64'd7);

    // x0 destination still retires
    drive(1, 1, 2'd0, 3'd0, 5'd0, 32'h55, 32'h0, 32'h0); tick();
    chk("x0_rw", 64'(reg_write_w), 64'd0);
    chk("x0_valid", 64'(valid_w), 64'd1);
    idle(); tick();
    chk("x0_instret", instret, 64'd8);

    // JAL link value, then reset mid-stream
    drive(1, 1, 2'd2, 3'd0, 5'd1, 32'h999, 32'h0, 32'h104); tick();
    chk("jal_result", 64'(result_w), 64'h104);
    chk("jal_rw", 64'(reg_write_w), 64'd1);
    reset = 1; tick();
    reset = 0;
    chk("midrst_valid", 64'(valid_w), 64'd0);
    chk("midrst_rw", 64'(reg_write_w), 64'd0);
    chk("midrst_instret", instret, 64'd0);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      int r;
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom), 2'($urandom), 3'($urandom),
            5'($urandom_range(0, 7)), $urandom, $urandom, $urandom);
      r = $urandom_range(0, 99);
      stall_w = (r < 15);
      flush_w = (r >= 15 && r < 23);
      reset   = ($urandom_range(0, 199) == 0);
      tick();
    end
    stall_w = 0; flush_w = 0; reset = 0; idle();
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
